// File: rtl/transmissor_uart_jogo.sv
// UART 8N1 serializer for the game-state snapshot (3-byte frame, 4 bytes with a
// trailing XOR checksum when UART_CHECKSUM_EN is defined).
module transmissor_uart_jogo #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       envia,
    input  logic [3:0] estado,
    input  logic [3:0] macro,
    input  logic [3:0] micro,
    input  logic [1:0] resultado_macro,
    input  logic [1:0] resultado_jogo,
    output logic       tx,
    output logic       ocupado,
    output logic       pronto,
    output logic [3:0] db_estado
);

    // state  | meaning
    // OCIOSO | idle, line high, waiting for envia
    // INICIO | start bit of the current byte
    // DADOS  | 8 data bits, LSB first
    // PARADA | stop bit; next byte or end of frame
    // FIM    | frame done, pronto high for this one cycle
    typedef enum logic [3:0] {
        OCIOSO = 4'd0,
        INICIO = 4'd1,
        DADOS  = 4'd2,
        PARADA = 4'd3,
        FIM    = 4'd4
    } fsm_t;

    localparam int TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] TMR_ULTIMO = TW'(CLKS_PER_BIT - 1);
`ifdef UART_CHECKSUM_EN
    localparam logic [1:0] ULTIMO_BYTE = 2'd3;
`else
    localparam logic [1:0] ULTIMO_BYTE = 2'd2;
`endif

    fsm_t          fsm_q, fsm_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [1:0]    byte_idx_q, byte_idx_d;

    logic [3:0]    est_q, est_d;
    logic [3:0]    mac_q, mac_d;
    logic [3:0]    mic_q, mic_d;
    logic [1:0]    rm_q, rm_d;
    logic [1:0]    rj_q, rj_d;

    logic          tx_q, tx_d;
    logic          ocupado_q, ocupado_d;
    logic          pronto_q, pronto_d;
    logic [3:0]    db_q, db_d;

    logic          tmr_fim;
    logic          captura;
    logic [7:0]    byte_b0, byte_b1, byte_b2;
    logic [7:0]    byte_atual;

    always_comb begin
        byte_b0 = {4'hA, est_q};
        byte_b1 = {mac_q, mic_q};
        byte_b2 = {4'h5, rm_q, rj_q};
        case (byte_idx_q)
            2'd0:    byte_atual = byte_b0;
            2'd1:    byte_atual = byte_b1;
`ifdef UART_CHECKSUM_EN
            2'd2:    byte_atual = byte_b2;
            default: byte_atual = byte_b0 ^ byte_b1 ^ byte_b2;
`else
            default: byte_atual = byte_b2;
`endif
        endcase
    end

    // Next-state and counter logic; the bit timer wraps at every bit boundary.
    always_comb begin
        fsm_d      = fsm_q;
        tmr_d      = tmr_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        captura    = 1'b0;
        tmr_fim    = (tmr_q == TMR_ULTIMO);

        case (fsm_q)
            OCIOSO, FIM: begin
                tmr_d      = '0;
                bit_idx_d  = 3'd0;
                byte_idx_d = 2'd0;
                if (envia) begin
                    fsm_d   = INICIO;
                    captura = 1'b1;
                end else begin
                    fsm_d = OCIOSO;
                end
            end
            INICIO: begin
                tmr_d = tmr_fim ? '0 : tmr_q + TW'(1);
                if (tmr_fim) begin
                    fsm_d = DADOS;
                end
            end
            DADOS: begin
                tmr_d = tmr_fim ? '0 : tmr_q + TW'(1);
                if (tmr_fim) begin
                    if (bit_idx_q == 3'd7) begin
                        fsm_d     = PARADA;
                        bit_idx_d = 3'd0;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            PARADA: begin
                tmr_d = tmr_fim ? '0 : tmr_q + TW'(1);
                if (tmr_fim) begin
                    if (byte_idx_q == ULTIMO_BYTE) begin
                        fsm_d      = FIM;
                        byte_idx_d = 2'd0;
                    end else begin
                        fsm_d      = INICIO;
                        byte_idx_d = byte_idx_q + 2'd1;
                    end
                end
            end
            default: begin
                fsm_d      = OCIOSO;
                tmr_d      = '0;
                bit_idx_d  = 3'd0;
                byte_idx_d = 2'd0;
            end
        endcase
    end

    always_comb begin
        est_d = est_q;
        mac_d = mac_q;
        mic_d = mic_q;
        rm_d  = rm_q;
        rj_d  = rj_q;
        if (captura) begin
            est_d = estado;
            mac_d = macro;
            mic_d = micro;
            rm_d  = resultado_macro;
            rj_d  = resultado_jogo;
        end
    end

    // Outputs are decoded from the next state so they register in step with it.
    always_comb begin
        tx_d = 1'b1;
        case (fsm_d)
            INICIO:  tx_d = 1'b0;
            DADOS:   tx_d = byte_atual[bit_idx_d];
            default: tx_d = 1'b1;
        endcase
        ocupado_d = (fsm_d == INICIO) || (fsm_d == DADOS) || (fsm_d == PARADA);
        pronto_d  = (fsm_d == FIM);
        db_d      = fsm_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fsm_q      <= OCIOSO;
            tmr_q      <= '0;
            bit_idx_q  <= 3'd0;
            byte_idx_q <= 2'd0;
            est_q      <= 4'd0;
            mac_q      <= 4'd0;
            mic_q      <= 4'd0;
            rm_q       <= 2'd0;
            rj_q       <= 2'd0;
            tx_q       <= 1'b1;
            ocupado_q  <= 1'b0;
            pronto_q   <= 1'b0;
            db_q       <= 4'd0;
        end else begin
            fsm_q      <= fsm_d;
            tmr_q      <= tmr_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            est_q      <= est_d;
            mac_q      <= mac_d;
            mic_q      <= mic_d;
            rm_q       <= rm_d;
            rj_q       <= rj_d;
            tx_q       <= tx_d;
            ocupado_q  <= ocupado_d;
            pronto_q   <= pronto_d;
            db_q       <= db_d;
        end
    end

    assign tx        = tx_q;
    assign ocupado   = ocupado_q;
    assign pronto    = pronto_q;
    assign db_estado = db_q;

endmodule

// File: tb/tb_transmissor_uart_jogo.sv
// Bench for transmissor_uart_jogo: table vectors, random snapshots, and
// hand sequences for snapshot hold, mid-frame envia, chaining and reset abort.
module tb_transmissor_uart_jogo;

    localparam int C = 4;
`ifdef UART_CHECKSUM_EN
    localparam int NB = 4;
`else
    localparam int NB = 3;
`endif
    localparam int L = 10 * NB * C;

    logic       clock;
    logic       reset;
    logic       envia;
    logic [3:0] estado;
    logic [3:0] macro;
    logic [3:0] micro;
    logic [1:0] resultado_macro;
    logic [1:0] resultado_jogo;
    logic       tx;
    logic       ocupado;
    logic       pronto;
    logic [3:0] db_estado;

    int n_chk  = 0;
    int n_fail = 0;

    transmissor_uart_jogo #(.CLKS_PER_BIT(C)) dut (
        .clock           (clock),
        .reset           (reset),
        .envia           (envia),
        .estado          (estado),
        .macro           (macro),
        .micro           (micro),
        .resultado_macro (resultado_macro),
        .resultado_jogo  (resultado_jogo),
        .tx              (tx),
        .ocupado         (ocupado),
        .pronto          (pronto),
        .db_estado       (db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] e, m, mi;
        logic [1:0] rm, rj;
        logic [7:0] b0, b1, b2;
    } vec_t;

    vec_t tab[4];

    task automatic check(input string nome, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nome, got, exp);
        end
    endtask

    // Frame bytes packed {b3,b2,b1,b0}; b3 is only transmitted with the checksum.
    function automatic logic [31:0] model_bytes(input logic [3:0] e, input logic [3:0] m,
                                                input logic [3:0] mi, input logic [1:0] rm,
                                                input logic [1:0] rj);
        int b0, b1, b2, b3;
        b0 = 160 + int'(e);
        b1 = int'(m) * 16 + int'(mi);
        b2 = 80 + int'(rm) * 4 + int'(rj);
        b3 = b0 ^ b1 ^ b2;
        return {b3[7:0], b2[7:0], b1[7:0], b0[7:0]};
    endfunction

    // Expected {tx, ocupado, pronto, db_estado} in cycle i after acceptance.
    function automatic logic [6:0] model_linha(input logic [31:0] bytes, input int i);
        int bitn, by, pos;
        logic t;
        logic [3:0] st;
        if (i >= 1 && i <= L) begin
            bitn = (i - 1) / C;
            by   = bitn / 10;
            pos  = bitn % 10;
            if (pos == 0) begin
                t = 1'b0; st = 4'd1;
            end else if (pos == 9) begin
                t = 1'b1; st = 4'd3;
            end else begin
                t = bytes[by * 8 + pos - 1]; st = 4'd2;
            end
            return {t, 1'b1, 1'b0, st};
        end
        if (i == L + 1) return {1'b1, 1'b0, 1'b1, 4'd4};
        return {1'b1, 1'b0, 1'b0, 4'd0};
    endfunction

    task automatic drive(input logic [3:0] e, input logic [3:0] m, input logic [3:0] mi,
                         input logic [1:0] rm, input logic [1:0] rj);
        estado = e; macro = m; micro = mi; resultado_macro = rm; resultado_jogo = rj;
        envia = 1'b1;
    endtask

    // Called at a negedge right after envia was raised; follows the whole frame.
    task automatic run_frame(input logic [31:0] exp, input bit perturb, input bit chain,
                             input string nome);
        int pr;
        int bitn, pos;
        logic [7:0] rx[4];
        pr = 0;
        for (int b = 0; b < 4; b++) rx[b] = 8'h00;
        for (int i = 1; i <= L + 1; i++) begin
            @(negedge clock);
            if (i == 1) envia = 1'b0;
            check($sformatf("%s cycle %0d", nome, i), {25'd0, tx, ocupado, pronto, db_estado},
                  {25'd0, model_linha(exp, i)});
            if (pronto) pr++;
            if (i <= L && ((i - 1) % C) == C / 2) begin
                bitn = (i - 1) / C;
                pos  = bitn % 10;
                if (pos >= 1 && pos <= 8) rx[bitn / 10][pos - 1] = tx;
            end
            if (perturb) begin
                if (i == 10) begin
                    estado = 4'hF; macro = 4'hF; micro = 4'hF;
                    resultado_macro = 2'b11; resultado_jogo = 2'b11;
                end
                if (i == 50) envia = 1'b1;
                if (i == 51) envia = 1'b0;
            end
            if (chain && i == L + 1) envia = 1'b1;
        end
        for (int b = 0; b < NB; b++)
            check($sformatf("%s byte %0d", nome, b), {24'd0, rx[b]}, {24'd0, exp[b * 8 +: 8]});
        if (!chain) begin
            @(negedge clock);
            check($sformatf("%s idle", nome), {25'd0, tx, ocupado, pronto, db_estado},
                  {25'd0, 7'b1000000});
            if (pronto) pr++;
        end
        check($sformatf("%s pronto count", nome), pr, 1);
    endtask

    logic [31:0] exp_b;
    int          bad;

    initial begin
        tab[0] = '{e: 4'h3, m: 4'h5, mi: 4'h7, rm: 2'b01, rj: 2'b10, b0: 8'hA3, b1: 8'h57, b2: 8'h56};
        tab[1] = '{e: 4'h0, m: 4'h0, mi: 4'h0, rm: 2'b00, rj: 2'b00, b0: 8'hA0, b1: 8'h00, b2: 8'h50};
        tab[2] = '{e: 4'hF, m: 4'hF, mi: 4'hF, rm: 2'b11, rj: 2'b11, b0: 8'hAF, b1: 8'hFF, b2: 8'h5F};
        tab[3] = '{e: 4'h9, m: 4'h2, mi: 4'hC, rm: 2'b10, rj: 2'b01, b0: 8'hA9, b1: 8'h2C, b2: 8'h59};

        reset = 1'b1; envia = 1'b0;
        estado = 4'd0; macro = 4'd0; micro = 4'd0; resultado_macro = 2'd0; resultado_jogo = 2'd0;
        repeat (3) @(negedge clock);
        check("reset state", {25'd0, tx, ocupado, pronto, db_estado}, {25'd0, 7'b1000000});
        envia = 1'b1;
        @(negedge clock);
        check("reset beats envia", {25'd0, tx, ocupado, pronto, db_estado}, {25'd0, 7'b1000000});
        envia = 1'b0; reset = 1'b0;
        repeat (2) @(negedge clock);
        check("idle after reset", {25'd0, tx, ocupado, pronto, db_estado}, {25'd0, 7'b1000000});

        for (int k = 0; k < 4; k++) begin
            drive(tab[k].e, tab[k].m, tab[k].mi, tab[k].rm, tab[k].rj);
            exp_b = {tab[k].b0 ^ tab[k].b1 ^ tab[k].b2, tab[k].b2, tab[k].b1, tab[k].b0};
            run_frame(exp_b, 1'b0, 1'b0, $sformatf("table %0d", k));
        end

        exp_b = {tab[0].b0 ^ tab[0].b1 ^ tab[0].b2, tab[0].b2, tab[0].b1, tab[0].b0};
        drive(tab[0].e, tab[0].m, tab[0].mi, tab[0].rm, tab[0].rj);
        run_frame(exp_b, 1'b1, 1'b0, "snapshot hold");

        drive(tab[0].e, tab[0].m, tab[0].mi, tab[0].rm, tab[0].rj);
        run_frame(exp_b, 1'b0, 1'b1, "chain first");
        run_frame(exp_b, 1'b0, 1'b0, "chain second");

        drive(tab[3].e, tab[3].m, tab[3].mi, tab[3].rm, tab[3].rj);
        for (int i = 1; i <= 60; i++) begin
            @(negedge clock);
            if (i == 1) envia = 1'b0;
        end
        reset = 1'b1;
        @(negedge clock);
        check("abort outputs", {25'd0, tx, ocupado, pronto, db_estado}, {25'd0, 7'b1000000});
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < L + 5; i++) begin
            @(negedge clock);
            if (pronto || ocupado || !tx) bad++;
        end
        check("no activity after abort", bad, 0);
        drive(tab[2].e, tab[2].m, tab[2].mi, tab[2].rm, tab[2].rj);
        exp_b = {tab[2].b0 ^ tab[2].b1 ^ tab[2].b2, tab[2].b2, tab[2].b1, tab[2].b0};
        run_frame(exp_b, 1'b0, 1'b0, "after abort");

        for (int r = 0; r < 6; r++) begin
            logic [3:0] e, m, mi;
            logic [1:0] rm, rj;
            e  = 4'($urandom_range(0, 15));
            m  = 4'($urandom_range(0, 15));
            mi = 4'($urandom_range(0, 15));
            rm = 2'($urandom_range(0, 3));
            rj = 2'($urandom_range(0, 3));
            repeat ($urandom_range(0, 3)) @(negedge clock);
            drive(e, m, mi, rm, rj);
            run_frame(model_bytes(e, m, mi, rm, rj), 1'b0, 1'b0, $sformatf("random %0d", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/transmissor_uart_jogo.md
# transmissor_uart_jogo

Serializes the game-state snapshot that the game circuit exposes on its UART debug outputs (`uart_estado`, `uart_macro`, `uart_micro`, `uart_resulado_macro`, `uart_resulado_jogo`) into a fixed multi-byte 8N1 UART frame for the host-side board viewer. It sits directly downstream of the game circuit. On a one-cycle request it latches one snapshot, shifts it out on a single TX line and pulses completion.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 434: clock cycles per UART bit (50 MHz / 115200); legal minimum 2.

Ports:
- `clock`  in  1  sole clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `envia`  in  1  one-cycle send request; sampled only in OCIOSO or FIM.
- `estado`  in  4  FSM state code of the game circuit.
- `macro`  in  4  current macro-board index.
- `micro`  in  4  current micro-cell index.
- `resultado_macro`  in  2  macro-board result code.
- `resultado_jogo`  in  2  game result code.
- `tx`  out  1  UART serial line; idle high.
- `ocupado`  out  1  high while a frame is in flight.
- `pronto`  out  1  one-cycle pulse when the last stop bit completes.
- `db_estado`  out  4  internal FSM state code, for a HEX display.

## Operation
- Snapshot: on an accepted `envia`, all five inputs are latched together.
  - Inputs changing afterwards do not affect the frame in flight.
- Frame bytes, in transmission order:
  - B0 = {4'hA, estado}
  - B1 = {macro, micro}
  - B2 = {4'h5, resultado_macro, resultado_jogo}
- Each byte is sent as: start bit 0, then 8 data bits LSB first, then stop bit 1.
- Bytes go back-to-back with no idle gap.
- FSM states and `db_estado` codes:
  - OCIOSO=0
  - INICIO=1
  - DADOS=2
  - PARADA=3
  - FIM=4
- Transitions:
  - OCIOSO to INICIO when `envia` is high.
  - INICIO to DADOS after one bit period.
  - DADOS to PARADA after 8 bit periods.
  - PARADA to INICIO after one bit period, if bytes remain; the byte index increments.
  - PARADA to FIM after one bit period, if no bytes remain.
  - FIM to INICIO if `envia` is high, otherwise FIM to OCIOSO.
- Bit timer counts 0..CLKS_PER_BIT-1 and wraps at each bit boundary.
- Bit index counts 0..7; byte index counts 0..N-1 (N=3, or 4 with the checksum enabled).
- `envia` asserted in INICIO, DADOS or PARADA is ignored; no queueing.
- Outputs are registered: `tx` = 1 in OCIOSO and FIM.
- `ocupado` = 1 exactly in INICIO, DADOS and PARADA.
- `pronto` = 1 only in FIM.

## Timing
- Reset values: `tx`=1, `ocupado`=0, `pronto`=0, `db_estado`=0, all counters 0.
- Reset asserted mid-frame aborts the frame. On the next edge `tx`=1 and `ocupado`=0, and no `pronto` is produced.
- `envia` sampled high at edge t:
  - `tx` falls and `ocupado` rises at t+1.
  - Each bit holds for exactly CLKS_PER_BIT cycles.
- Frame length is 10·N·CLKS_PER_BIT cycles.
- `pronto` is high for exactly one cycle at t+1+10·N·CLKS_PER_BIT; `ocupado` is 0 in that same cycle.
- `envia` in the FIM cycle is accepted. `tx` falls on the next edge, which gives back-to-back frames with zero idle bits.
- Simultaneous `reset` and `envia`: reset wins.

## Configuration
- `UART_CHECKSUM_EN` defined:
  - N=4; a fourth byte B3 = B0 ^ B1 ^ B2 is appended after B2.
  - Frame length is 40·CLKS_PER_BIT cycles.
- Undefined: N=3; the frame ends after B2 and no checksum logic is present.

## Test plan
- CLKS_PER_BIT=4, no checksum; inputs `estado`=3, `macro`=5, `micro`=7, `resultado_macro`=2'b01, `resultado_jogo`=2'b10; pulse `envia` at t.
  - Required: `tx` decodes to bytes 0xA3, 0x57, 0x56.
  - Required: `pronto` is a single pulse at t+121.
  - Required: `ocupado` is high for exactly 120 cycles.
- Same stimulus with `UART_CHECKSUM_EN`.
  - Required: a fourth byte 0xA2 follows.
  - Required: `pronto` at t+161.
- Change all inputs to 0xF/2'b11 at t+10.
  - Required: the bytes are unchanged (0xA3, 0x57, 0x56).
- Re-pulse `envia` at t+50 mid-frame.
  - Required: it is ignored, exactly one frame is sent and exactly one `pronto` occurs.
- Pulse `envia` in the FIM cycle.
  - Required: the next start bit begins the following edge, and `tx` shows no high idle bit between frames.
- Assert `reset` at t+60, during B1.
  - Required: `tx`=1, `ocupado`=0 and `db_estado`=0 on the next edge.
  - Required: no `pronto` follows, and a later `envia` produces a correct full frame.
